// File: rtl/ecg_feed_pkg.sv
// Shared types, defaults and helpers for the ECG frame feeder.
package ecg_feed_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RES = 2'd2
  } state_t;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_FRAME_LEN   = 144;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_TIMEOUT_CYC = 65535;

  // Ceiling log2, never below 1 so counters always have a bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ecg_frame_ram.sv
// Frame buffer: simple dual-port RAM, one write port, one registered read port.
module ecg_frame_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 144,
  parameter int ADDR_W = 8
) (
  input  logic              ap_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // rdata holds when re is low; the feeder uses it as a stall-able pipeline stage.
  always_ff @(posedge ap_clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ecg_frame_feeder.sv
// Streams a buffered ECG frame into the FINN accelerator and latches its class byte.
// Optional ECG_FEED_TLAST_EN adds m_axis_0_tlast / s_axis_0_tlast frame markers.
module ecg_frame_feeder
  import ecg_feed_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FRAME_LEN   = DEF_FRAME_LEN,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              err_timeout,
  output logic [DATA_W-1:0] m_axis_0_tdata,
  output logic              m_axis_0_tvalid,
  input  logic              m_axis_0_tready,
`ifdef ECG_FEED_TLAST_EN
  output logic              m_axis_0_tlast,
  input  logic              s_axis_0_tlast,
`endif
  input  logic [DATA_W-1:0] s_axis_0_tdata,
  input  logic              s_axis_0_tvalid,
  output logic              s_axis_0_tready
);

  localparam int CNT_W  = clog2(FRAME_LEN);
  localparam int TW     = clog2(TIMEOUT_CYC + 1);
  localparam int STAGES = 2;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [TW-1:0]     TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W:0]   FL_A     = (ADDR_W + 1)'(FRAME_LEN);

  state_t state, state_nxt;

  logic [CNT_W-1:0]  fetch_idx, snd_idx;
  logic              fetch_done;
  logic [STAGES:1]   vld_pipe;   // [1] RAM read data, [2] output register
  logic [DATA_W-1:0] ram_q, out_q;
  logic [TW-1:0]     tcnt;
  logic              rd_en, wr_en, start_acc;
  logic              rdy_out, rdy_ram, out_fire, last_fire, res_fire, to_fire;

  // Stall-able two-stage pipeline: a stage advances when the next one is empty or draining.
  assign rdy_out   = !vld_pipe[2] || m_axis_0_tready;
  assign rdy_ram   = !vld_pipe[1] || rdy_out;
  assign out_fire  = vld_pipe[2] && m_axis_0_tready;
  assign last_fire = out_fire && (snd_idx == LAST_IDX);
  assign start_acc = (state == IDLE) && start;
  assign res_fire  = (state == WAIT_RES) && s_axis_0_tvalid;
  assign to_fire   = (state == WAIT_RES) && !s_axis_0_tvalid && (tcnt == TO_LAST);

  // The first read issues on the start cycle so tvalid rises two cycles later.
  assign rd_en = start_acc || ((state == SEND) && !fetch_done && rdy_ram);
  assign wr_en = ld_we && (state == IDLE) && ({1'b0, ld_addr} < FL_A);

  assign busy            = (state != IDLE);
  assign m_axis_0_tvalid = vld_pipe[2];
  assign m_axis_0_tdata  = out_q;
  assign s_axis_0_tready = (state == WAIT_RES);
`ifdef ECG_FEED_TLAST_EN
  assign m_axis_0_tlast  = vld_pipe[2] && (snd_idx == LAST_IDX);
`endif

  ecg_frame_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (FRAME_LEN),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .ap_clk (ap_clk),
    .we     (wr_en),
    .waddr  (ld_addr),
    .wdata  (ld_data),
    .re     (rd_en),
    .raddr  (ADDR_W'(fetch_idx)),
    .rdata  (ram_q)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = SEND;
      SEND:     if (last_fire) state_nxt = WAIT_RES;
      WAIT_RES: if (res_fire || to_fire) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state        <= IDLE;
      vld_pipe     <= '0;
      out_q        <= '0;
      fetch_idx    <= '0;
      fetch_done   <= 1'b0;
      snd_idx      <= '0;
      tcnt         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err_timeout  <= 1'b0;
      done         <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= res_fire || to_fire;

      if (rd_en)        vld_pipe[1] <= 1'b1;
      else if (rdy_out) vld_pipe[1] <= 1'b0;
      if (rdy_out) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) out_q <= ram_q;
      end

      if (rd_en) begin
        if (fetch_idx == LAST_IDX) fetch_done <= 1'b1;
        else                       fetch_idx  <= fetch_idx + 1'b1;
      end else if (state == IDLE) begin
        fetch_idx  <= '0;
        fetch_done <= 1'b0;
      end

      if (state == IDLE)                          snd_idx <= '0;
      else if (out_fire && snd_idx != LAST_IDX)   snd_idx <= snd_idx + 1'b1;

      if (state != WAIT_RES)  tcnt <= '0;
      else if (tcnt != '1)    tcnt <= tcnt + 1'b1;

      if (start_acc) begin
        result_valid <= 1'b0;
        err_timeout  <= 1'b0;
      end
      if (res_fire) begin
        result       <= s_axis_0_tdata;
        result_valid <= 1'b1;
`ifdef ECG_FEED_TLAST_EN
        // A result without its frame marker is kept but flagged.
        if (!s_axis_0_tlast) err_timeout <= 1'b1;
`endif
      end
      if (to_fire) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ecg_frame_feeder.sv
// Directed, table-driven bench for ecg_frame_feeder (TIMEOUT_CYC=100).
module tb_ecg_frame_feeder;

  localparam int FL = 144;
`ifdef ECG_FEED_TLAST_EN
  localparam bit TL = 1'b1;
`else
  localparam bit TL = 1'b0;
`endif

  logic       ap_clk, ap_rst;
  logic       ld_we, start;
  logic [7:0] ld_addr, ld_data;
  logic       busy, done, result_valid, err_timeout;
  logic [7:0] result, m_axis_0_tdata, s_axis_0_tdata;
  logic       m_axis_0_tvalid, m_axis_0_tready, m_axis_0_tlast;
  logic       s_axis_0_tvalid, s_axis_0_tready, s_axis_0_tlast;

  ecg_frame_feeder #(.TIMEOUT_CYC(100)) dut (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .ld_we           (ld_we),
    .ld_addr         (ld_addr),
    .ld_data         (ld_data),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .result          (result),
    .result_valid    (result_valid),
    .err_timeout     (err_timeout),
    .m_axis_0_tdata  (m_axis_0_tdata),
    .m_axis_0_tvalid (m_axis_0_tvalid),
    .m_axis_0_tready (m_axis_0_tready),
`ifdef ECG_FEED_TLAST_EN
    .m_axis_0_tlast  (m_axis_0_tlast),
    .s_axis_0_tlast  (s_axis_0_tlast),
`endif
    .s_axis_0_tdata  (s_axis_0_tdata),
    .s_axis_0_tvalid (s_axis_0_tvalid),
    .s_axis_0_tready (s_axis_0_tready)
  );

`ifndef ECG_FEED_TLAST_EN
  assign m_axis_0_tlast = 1'b0;
`endif

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [7:0] seed;      // frame byte i = seed + i
    bit         load;      // reload buffer before the run
    bit         tog;       // toggle m_axis_0_tready every cycle
    bit         inj;       // start + ld_we(addr 5, 0xFF) right after start
    bit         rep_en;    // accelerator answers
    int         dly;       // answer this many cycles after entering WAIT_RES
    logic [7:0] rep;
    bit         rep_last;
    logic [7:0] exp_res;
    bit         exp_valid;
    bit         exp_err;
    int         exp_wait;  // cycles from WAIT_RES entry to done
  } run_t;

  run_t tbl [6];
  int   n_chk = 0, n_err = 0, cur_run = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s run%0d: got %0d expected %0d", nm, cur_run, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] seed);
    for (int i = 0; i < FL; i++) begin
      ld_we = 1'b1; ld_addr = 8'(i); ld_data = seed + 8'(i);
      @(posedge ap_clk); #1;
    end
    ld_we = 1'b0;
  endtask

  task automatic do_run(input run_t r, output int beats, output int dones,
                        output int bad, output int first_k, output int wait_cyc);
    logic [7:0] exp_b, hold_d;
    bit hold_v, rep_done;
    int k, last_k, done_k;
    beats = 0; dones = 0; bad = 0; first_k = -1; wait_cyc = -1;
    last_k = -1; done_k = -1; hold_v = 0; hold_d = '0; rep_done = 0;
    start = 1'b1;
    @(posedge ap_clk); #1;
    k = 1;
    while (k < 1000) begin
      if (hold_v && (!m_axis_0_tvalid || m_axis_0_tdata !== hold_d)) bad++;
      if (m_axis_0_tvalid && first_k < 0) first_k = k;
      if (done) begin dones++; if (done_k < 0) done_k = k; end
      if (r.inj && k == 1) begin
        start = 1'b1; ld_we = 1'b1; ld_addr = 8'd5; ld_data = 8'hFF;
      end else begin
        start = 1'b0; ld_we = 1'b0;
      end
      m_axis_0_tready = r.tog ? k[0] : 1'b1;
      hold_v = m_axis_0_tvalid && !m_axis_0_tready;
      hold_d = m_axis_0_tdata;
      if (m_axis_0_tvalid && m_axis_0_tready) begin
        exp_b = r.seed + 8'(beats);
        if (m_axis_0_tdata !== exp_b) bad++;
        if (TL && (m_axis_0_tlast !== (beats == FL - 1))) bad++;
        beats++;
        if (beats == FL) last_k = k + 1;
      end
      s_axis_0_tvalid = 1'b0;
      if (r.rep_en && last_k >= 0 && !rep_done && (k - last_k) >= r.dly) begin
        s_axis_0_tvalid = 1'b1; s_axis_0_tdata = r.rep; s_axis_0_tlast = r.rep_last;
        if (s_axis_0_tready) rep_done = 1;
      end
      if (done_k >= 0 && k >= done_k + 3) break;
      @(posedge ap_clk); #1;
      k++;
    end
    s_axis_0_tvalid = 1'b0;
    if (done_k >= 0 && last_k >= 0) wait_cyc = done_k - last_k;
  endtask

  task automatic check_run(input run_t r);
    int beats, dones, bad, fk, wc;
    if (r.load) load(r.seed);
    do_run(r, beats, dones, bad, fk, wc);
    chk("beat_count", 32'(beats), 32'(FL));
    chk("beat_errors", 32'(bad), 32'd0);
    chk("done_pulses", 32'(dones), 32'd1);
    chk("first_tvalid_cycle", 32'(fk), 32'd2);
    chk("wait_to_done", 32'(wc), 32'(r.exp_wait));
    chk("result", 32'(result), 32'(r.exp_res));
    chk("result_valid", 32'(result_valid), 32'(r.exp_valid));
    chk("err_timeout", 32'(err_timeout), 32'(r.exp_err));
    chk("idle_outputs", {29'd0, busy, m_axis_0_tvalid, s_axis_0_tready}, 32'd0);
  endtask

  initial begin
    int n;
    run_t rr;
    //          seed  ld tog inj rep dly rep    last exp_res val err  wait
    tbl[0] = '{8'h00, 1, 0,  0,  1,  10, 8'h03, 1,   8'h03,  1,  0,   11};
    tbl[1] = '{8'h00, 1, 1,  0,  1,  0,  8'h5A, 1,   8'h5A,  1,  0,   1};
    tbl[2] = '{8'h40, 1, 0,  0,  0,  0,  8'h00, 1,   8'h5A,  0,  1,   100};
    tbl[3] = '{8'h40, 0, 1,  0,  1,  99, 8'h7E, 1,   8'h7E,  1,  0,   100};
    tbl[4] = '{8'hF0, 1, 0,  1,  1,  98, 8'h11, 1,   8'h11,  1,  0,   99};
    tbl[5] = '{8'hF0, 0, 0,  0,  1,  5,  8'h01, 0,   8'h01,  1,  TL,  6};

    ap_rst = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
    m_axis_0_tready = 1'b0; s_axis_0_tvalid = 1'b0; s_axis_0_tdata = '0; s_axis_0_tlast = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    chk("reset_flags", {26'd0, busy, done, result_valid, err_timeout, m_axis_0_tvalid, s_axis_0_tready}, 32'd0);
    chk("reset_data", {16'd0, result, m_axis_0_tdata}, 32'd0);
    chk("reset_tlast", 32'(m_axis_0_tlast), 32'd0);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;

    foreach (tbl[i]) begin
      cur_run = i;
      check_run(tbl[i]);
    end

    // Reset in the middle of the frame, then rerun from the untouched buffer.
    cur_run = 6;
    load(8'h00);
    start = 1'b1; m_axis_0_tready = 1'b1; n = 0;
    @(posedge ap_clk); #1;
    start = 1'b0;
    for (int k = 0; k < 400 && n < 50; k++) begin
      if (m_axis_0_tvalid) n++;
      if (n < 50) begin @(posedge ap_clk); #1; end
    end
    chk("beats_before_reset", 32'(n), 32'd50);
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0; m_axis_0_tready = 1'b0;
    chk("midrun_reset_flags", {26'd0, busy, done, result_valid, err_timeout, m_axis_0_tvalid, s_axis_0_tready}, 32'd0);
    chk("midrun_reset_data", {16'd0, result, m_axis_0_tdata}, 32'd0);
    n = 0;
    repeat (5) begin
      @(posedge ap_clk); #1;
      if (done || m_axis_0_tvalid || busy) n++;
    end
    chk("no_activity_after_reset", 32'(n), 32'd0);
    rr = '{8'h00, 0, 0, 0, 1, 3, 8'h22, 1, 8'h22, 1, 0, 4};
    check_run(rr);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
